stream_demux_1xn: RTL
=====================

# stream_demux_1xn

Registered, handshaked 1-to-N stream demultiplexer: routes a W-bit beat arriving on one valid/ready input to one of N valid/ready output channels, selected per beat. It is the pipelined successor to the combinational 1xN demux and sits between a single producer (e.g. a packet parser) and N independent consumers that may stall. One holding stage is used, with full throughput when the target accepts, per-channel back-pressure, out-of-range select detection, and an optional broadcast mode.

## Interface
- N, default 4, number of output channels (N >= 2)
- W, default 8, data width in bits
- SEL_WIDTH, default $clog2(N), select width (derived; do not override)
- ERR_CNT_W, default 8, width of the dropped-beat counter

- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  W  input beat payload
- in_sel  input  SEL_WIDTH  destination channel index
- in_bcast  input  1  present only with DEMUX_BCAST_EN; beat goes to all channels
- out_valid  output  N  one-hot (or all-ones for broadcast) per-channel valid
- out_ready  input  N  per-channel ready
- out_data  output  W  shared payload bus, valid for every channel whose out_valid is high
- err_cnt  output  ERR_CNT_W  count of beats dropped for in_sel >= N
- busy  output  1  holding register occupied

## Operation
- Two states: IDLE (holding register empty), HOLD (beat held, pend mask nonzero).
- Accept = in_valid && in_ready. in_ready = !rst && (state==IDLE || (pend & ~out_ready) == 0).
- Accepted beat with in_sel < N: out_data <= in_data, pend <= one-hot(in_sel), state <= HOLD.
- Accepted beat with in_sel >= N (only possible if N is not a power of 2): beat consumed and dropped; pend/out_data unchanged if IDLE; err_cnt increments, saturating at all-ones; no output asserted.
- out_valid = pend. Each cycle, pend <= pend & ~out_ready; HOLD -> IDLE when that result is 0 and no new beat is accepted.
- Simultaneous drain and accept: last pending bit cleared and the new beat loaded on the same edge; no bubble.
- out_data and out_valid bits held stable while stalled; a channel's out_valid never drops before its out_ready.
- busy = (state==HOLD).

## Timing
- Latency: beat accepted at edge k appears on out_valid/out_data after edge k (cycle k+1).
- Throughput: one beat per cycle while each target channel's out_ready is high.
- Reset (rst high at an edge): state IDLE, pend 0, out_valid 0, out_data 0, err_cnt 0, busy 0; in_ready is 0 while rst is high and 1 the first cycle after.
- Reset mid-HOLD discards the held beat; no out_valid is asserted in the cycle after reset.
- in_valid without in_ready: nothing sampled; producer must hold the beat.

## Configuration
- DEMUX_BCAST_EN defined: in_bcast port exists; accepted beat with in_bcast=1 loads pend = all ones (in_sel ignored, never counted as error); each channel clears its bit independently on its own out_ready; the next beat is accepted only once the last pending bit is cleared (same-cycle rule above).
- Not defined: no in_bcast port; every beat is unicast per in_sel.

## Test plan
- N=4, W=8: send 0xA5 sel=2 with out_ready=4'b1111 -> out_valid=4'b0100, out_data=0xA5 one cycle after accept; in_ready stays 1.
- Back-to-back sel=0,1,2,3 with all ready -> out_valid 0001,0010,0100,1000 on consecutive cycles, no bubbles.
- sel=1 with out_ready[1]=0 for 5 cycles -> out_valid=0010 and out_data stable for 5 cycles, in_ready=0; beat retires on cycle out_ready[1] rises, next beat loads same edge.
- N=5: in_sel=6 and 7 -> no out_valid, err_cnt 0->1->2; with ERR_CNT_W=2 six bad beats -> err_cnt stuck at 3.
- DEMUX_BCAST_EN: bcast beat 0x3C, out_ready sequence 0001, 0100, 1010 -> out_valid 1111, 1110, 1010, 0000; in_ready high only in third cycle.
- rst asserted while HOLD with out_valid=0100 -> next cycle out_valid=0, busy=0, err_cnt=0, in_ready=0 until rst deasserts.

Source files
------------

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N valid/ready stream demultiplexer with one holding stage.
// Optional broadcast mode (in_bcast port) is enabled by defining DEMUX_BCAST_EN.
module stream_demux_1xn #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int SEL_WIDTH = $clog2(N),
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [SEL_WIDTH-1:0] in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic                 in_bcast,
`endif
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [W-1:0]         out_data,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state;
    logic [N-1:0]   pend;
    logic [N-1:0]   pend_left;
    logic [N-1:0]   onehot;
    logic           accept;
    logic           sel_bad;
    logic           is_bcast;

`ifdef DEMUX_BCAST_EN
    assign is_bcast = in_bcast;
`else
    assign is_bcast = 1'b0;
`endif

    // Bits still owed to stalled consumers after this cycle's handshakes.
    assign pend_left = pend & ~out_ready;
    assign in_ready  = !rst && (state == IDLE || pend_left == '0);
    assign accept    = in_valid && in_ready;
    assign sel_bad   = (int'(in_sel) >= N);
    assign onehot    = N'(1) << in_sel;

    assign out_valid = pend;
    assign busy      = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            out_data <= '0;
            err_cnt  <= '0;
        end else if (accept && (is_bcast || !sel_bad)) begin
            out_data <= in_data;
            pend     <= is_bcast ? '1 : onehot;
            state    <= HOLD;
        end else begin
            pend <= pend_left;
            if (pend_left == '0)
                state <= IDLE;
            // Out-of-range beats are swallowed; only the counter records them.
            if (accept && sel_bad && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
